// File: rtl/spi_frame_link_pkg.sv
// Shared types and constants for the framed SPI target link.
package spi_link_pkg;

  localparam int unsigned CMD_W        = 8;
  localparam int unsigned CMD_READ_BIT = 7;

  typedef enum logic [2:0] {
    ARMED = 3'd0,
    IDLE  = 3'd1,
    CMD   = 3'd2,
    RX    = 3'd3,
    TX    = 3'd4
  } link_state_e;

  // Number of SCK edges needed to move a field of the given width.
  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into clk and produces registered SCK and cs_n edge strobes.
module spi_pin_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sck_i,
  input  logic             cs_n_i,
  input  logic [WIDTH-1:0] sdi_i,
  output logic             sck_rise_o,
  output logic             sck_fall_o,
  output logic             cs_rise_o,
  output logic             cs_fall_o,
  output logic             cs_n_o,
  output logic [WIDTH-1:0] sdi_o
);

  localparam int unsigned N = WIDTH + 2;

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     prev_q;
  logic [N-1:0]     last_s;
  logic             sck_rise_q;
  logic             sck_fall_q;
  logic             cs_rise_q;
  logic             cs_fall_q;
  logic             cs_n_q;
  logic [WIDTH-1:0] sdi_q;

  assign last_s = sync_q[SYNC_STAGES-1];

  // Reset to all-zero so a held-low cs_n after reset never looks like a fresh falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      prev_q     <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_n_q     <= 1'b0;
      sdi_q      <= '0;
    end else begin
      sync_q[0] <= {sck_i, cs_n_i, sdi_i};
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q     <= last_s;
      sck_rise_q <= last_s[N-1] & ~prev_q[N-1];
      sck_fall_q <= ~last_s[N-1] & prev_q[N-1];
      cs_rise_q  <= last_s[N-2] & ~prev_q[N-2];
      cs_fall_q  <= ~last_s[N-2] & prev_q[N-2];
      cs_n_q     <= last_s[N-2];
      sdi_q      <= last_s[WIDTH-1:0];
    end
  end

  assign sck_rise_o = sck_rise_q;
  assign sck_fall_o = sck_fall_q;
  assign cs_rise_o  = cs_rise_q;
  assign cs_fall_o  = cs_fall_q;
  assign cs_n_o     = cs_n_q;
  assign sdi_o      = sdi_q;

endmodule

// File: rtl/spi_frame_link.sv
// Framed SPI target: command byte, then RX words or TX words fed from a one-deep hold buffer.
module spi_frame_link
  import spi_link_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic [LANES-1:0]  sdi,
  output logic [LANES-1:0]  sdo,
  output logic              sdo_oe,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_end,
  output logic              underrun
);

  localparam int unsigned CMD_BEATS  = beats(CMD_W, LANES);
  localparam int unsigned WORD_BEATS = beats(WORD_W, LANES);
  localparam int unsigned CNT_W      = $clog2(WORD_BEATS + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BEATS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BEATS - 1);

  logic             sck_rise_s;
  logic             sck_fall_s;
  logic             cs_rise_s;
  logic             cs_fall_s;
  logic             cs_n_s;
  logic [LANES-1:0] sdi_s;

  spi_pin_sync #(
    .WIDTH       (LANES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .sck_i      (sck),
    .cs_n_i     (cs_n),
    .sdi_i      (sdi),
    .sck_rise_o (sck_rise_s),
    .sck_fall_o (sck_fall_s),
    .cs_rise_o  (cs_rise_s),
    .cs_fall_o  (cs_fall_s),
    .cs_n_o     (cs_n_s),
    .sdi_o      (sdi_s)
  );

  link_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              cmd_valid_q;
  logic [WORD_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [LANES-1:0]  sdo_q;
  logic              sdo_oe_q;
  logic              tx_ready_q;
  logic              frame_end_q;
  logic              underrun_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] hold_d;
  logic              hold_full_q;
  logic              hold_full_d;
  logic              accept_s;
  logic              load_s;
  logic [WORD_W-1:0] tx_word_s;
  logic [WORD_W-1:0] shift_in_s;

  assign shift_in_s = {shift_q[WORD_W-LANES-1:0], sdi_s};

  // Hold-buffer bookkeeping: a load frees the slot before a same-cycle handshake refills it.
  always_comb begin
    accept_s  = tx_valid && tx_ready_q;
    load_s    = (state_q == TX) && sck_fall_s && !cs_rise_s && (cnt_q == '0);
    tx_word_s = hold_full_q ? hold_q : '0;
    hold_d    = accept_s ? tx_data : hold_q;
    if (cs_rise_s || (state_q != TX)) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = (hold_full_q && !load_s) || accept_s;
    end
  end

  // Hold buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Frame state machine with registered outputs; cs_n rising outranks any coincident SCK edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARMED;
      cnt_q       <= '0;
      shift_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sdo_q       <= '0;
      sdo_oe_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      frame_end_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_end_q <= 1'b0;
      underrun_q  <= 1'b0;
      if ((state_q != ARMED) && cs_rise_s) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        sdo_q       <= '0;
        sdo_oe_q    <= 1'b0;
        tx_ready_q  <= 1'b0;
        frame_end_q <= 1'b1;
      end else begin
        case (state_q)
          ARMED: begin
            tx_ready_q <= 1'b0;
            if (cs_n_s) begin
              state_q <= IDLE;
            end
          end
          IDLE: begin
            tx_ready_q <= 1'b0;
            if (cs_fall_s) begin
              state_q <= CMD;
              cnt_q   <= '0;
              shift_q <= '0;
            end
          end
          CMD: begin
            tx_ready_q <= 1'b0;
            if (sck_rise_s) begin
              shift_q <= shift_in_s;
              if (cnt_q == CMD_LAST) begin
                cmd_q       <= shift_in_s[CMD_W-1:0];
                cmd_valid_q <= 1'b1;
                cnt_q       <= '0;
                if (shift_in_s[CMD_READ_BIT]) begin
                  state_q  <= TX;
                  sdo_oe_q <= 1'b1;
                end else begin
                  state_q <= RX;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          RX: begin
            tx_ready_q <= 1'b0;
            if (sck_rise_s) begin
              shift_q <= shift_in_s;
              if (cnt_q == WORD_LAST) begin
                rx_data_q  <= shift_in_s;
                rx_valid_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          TX: begin
            tx_ready_q <= ~hold_full_d;
            if (load_s) begin
              sdo_q      <= tx_word_s[WORD_W-1 -: LANES];
              shift_q    <= {tx_word_s[WORD_W-LANES-1:0], {LANES{1'b0}}};
              cnt_q      <= WORD_LAST;
              underrun_q <= ~hold_full_q;
            end else if (sck_fall_s) begin
              sdo_q   <= shift_q[WORD_W-1 -: LANES];
              shift_q <= {shift_q[WORD_W-LANES-1:0], {LANES{1'b0}}};
              cnt_q   <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q    <= ARMED;
            tx_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sdo       = sdo_q;
  assign sdo_oe    = sdo_oe_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign frame_end = frame_end_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_frame_link.sv
// Directed bench for spi_frame_link: a 4-lane/16-bit instance and a 1-lane/8-bit instance.
module tb_spi_frame_link;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  sdi = 4'h0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        cs_n0;
  logic        cs_n1;

  logic [3:0]  sdo0;
  logic        sdo_oe0, cmd_valid0, rx_valid0, tx_ready0, frame_end0, underrun0;
  logic [7:0]  cmd0;
  logic [15:0] rx_data0;

  logic [0:0]  sdo1;
  logic        sdo_oe1, cmd_valid1, rx_valid1, tx_ready1, frame_end1, underrun1;
  logic [7:0]  cmd1;
  logic [7:0]  rx_data1;
  logic [7:0]  tx_data1 = 8'h00;
  logic        tx_valid1 = 1'b0;

  assign cs_n0 = cs_n | sel;
  assign cs_n1 = cs_n | ~sel;

  spi_frame_link #(.LANES(4), .WORD_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n0), .sdi(sdi),
    .sdo(sdo0), .sdo_oe(sdo_oe0), .cmd(cmd0), .cmd_valid(cmd_valid0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready0), .frame_end(frame_end0), .underrun(underrun0)
  );

  spi_frame_link #(.LANES(1), .WORD_W(8), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n1), .sdi(sdi[0:0]),
    .sdo(sdo1), .sdo_oe(sdo_oe1), .cmd(cmd1), .cmd_valid(cmd_valid1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .frame_end(frame_end1), .underrun(underrun1)
  );

  always #5 clk = ~clk;

  logic [7:0]  cmd_log[$];
  logic [15:0] rx_log[$];
  logic [7:0]  cmd1_log[$];
  logic [7:0]  rx1_log[$];
  int fe_cnt = 0;
  int ur_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int accepted = 0;

  always @(negedge clk) begin
    if (cmd_valid0) cmd_log.push_back(cmd0);
    if (rx_valid0) rx_log.push_back(rx_data0);
    if (cmd_valid1) cmd1_log.push_back(cmd1);
    if (rx_valid1) rx1_log.push_back(rx_data1);
    if (frame_end0) fe_cnt <= fe_cnt + 1;
    if (underrun0) ur_cnt <= ur_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] v, output logic [3:0] so, output logic oe, output logic rdy);
    sck = 1'b0;
    sdi = v;
    wait_cycles(H);
    so  = sdo0;
    oe  = sdo_oe0;
    rdy = tx_ready0;
    sck = 1'b1;
    wait_cycles(H);
  endtask

  task automatic send(input logic [31:0] data, input int nbits, input int lanes);
    logic [3:0]  so;
    logic        oe, rdy;
    logic [31:0] sh;
    logic [3:0]  m;
    m = (lanes == 4) ? 4'hF : 4'h1;
    for (int b = 0; b < nbits / lanes; b++) begin
      sh = data >> (nbits - (b + 1) * lanes);
      beat(sh[3:0] & m, so, oe, rdy);
    end
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wait_cycles(H);
  endtask

  // Raising cs_n together with the last SCK fall: the select edge must win.
  task automatic end_frame();
    sck  = 1'b0;
    cs_n = 1'b1;
    wait_cycles(2 * H);
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  so;
    logic        oe, rdy, oe_all, rdy_all;
    int          fe0, ur0;

    wait_cycles(4);
    check("reset_outs_a", {16'h0000, sdo0, sdo_oe0, cmd0, cmd_valid0, rx_valid0}, 32'h0);
    check("reset_outs_b", {15'h0000, rx_data0, tx_ready0}, 32'h0);
    rst = 1'b0;
    wait_cycles(20);

    // Write frame: cmd 0x12, words 0xBEEF and 0x0001.
    cmd_log.delete(); rx_log.delete(); fe0 = fe_cnt;
    start_frame();
    send(32'h12, 8, 4);
    send(32'hBEEF, 16, 4);
    send(32'h0001, 16, 4);
    end_frame();
    check("wr_cmd_count", cmd_log.size(), 1);
    check("wr_cmd", cmd_log[0], 8'h12);
    check("wr_rx_count", rx_log.size(), 2);
    check("wr_rx0", rx_log[0], 16'hBEEF);
    check("wr_rx1", rx_log[1], 16'h0001);
    check("wr_frame_end", fe_cnt - fe0, 1);

    // Read frame: cmd 0x80, host words 0xA5C3 then 0x1234.
    cmd_log.delete(); ur0 = ur_cnt; accepted = 0;
    word = 32'h0; oe_all = 1'b1;
    fork
      begin
        tx_data  = 16'hA5C3;
        tx_valid = 1'b1;
        for (int w = 0; w < 2; w++) begin
          int t;
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!tx_ready0 && t < 400);
          if (tx_ready0) begin
            @(posedge clk);
            #1;
            accepted++;
          end
          tx_data = 16'h1234;
        end
        tx_valid = 1'b0;
      end
      begin
        start_frame();
        send(32'h80, 8, 4);
        for (int i = 0; i < 8; i++) begin
          beat(4'h0, so, oe, rdy);
          word   = {word[27:0], so};
          oe_all = oe_all & oe;
        end
        end_frame();
      end
    join
    check("rd_cmd", cmd_log[0], 8'h80);
    check("rd_sdo_nibbles", word, 32'hA5C31234);
    check("rd_sdo_oe", oe_all, 1);
    check("rd_accepted", accepted, 2);
    check("rd_no_underrun", ur_cnt - ur0, 0);
    check("rd_idle_outs", {sdo0, sdo_oe0, tx_ready0}, 0);

    // Read underrun: cmd 0x81, nothing offered.
    ur0 = ur_cnt; word = 32'h0; rdy_all = 1'b1; oe_all = 1'b1;
    start_frame();
    send(32'h81, 8, 4);
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, so, oe, rdy);
      word    = {word[27:0], so};
      rdy_all = rdy_all & rdy;
      oe_all  = oe_all & oe;
    end
    end_frame();
    check("ur_sdo_zero", word, 32'h0);
    check("ur_pulses", ur_cnt - ur0, 1);
    check("ur_tx_ready_high", rdy_all, 1);
    check("ur_sdo_oe", oe_all, 1);

    // Abort after 2 of 4 beats of a write word, then a clean frame.
    cmd_log.delete(); rx_log.delete(); fe0 = fe_cnt;
    start_frame();
    send(32'h02, 8, 4);
    send(32'hAB, 8, 4);
    end_frame();
    check("ab_no_rx", rx_log.size(), 0);
    check("ab_frame_end", fe_cnt - fe0, 1);
    check("ab_cmd", cmd_log[0], 8'h02);
    cmd_log.delete();
    start_frame();
    send(32'h34, 8, 4);
    send(32'h5678, 16, 4);
    end_frame();
    check("ab_next_cmd", cmd_log[0], 8'h34);
    check("ab_next_rx", rx_log[0], 16'h5678);

    // Reset mid-frame with cs_n held low.
    start_frame();
    send(32'h1, 4, 4);
    rst = 1'b1;
    wait_cycles(3);
    check("mid_reset_outs_a", {16'h0000, sdo0, sdo_oe0, cmd0, cmd_valid0, rx_valid0}, 32'h0);
    check("mid_reset_outs_b", {15'h0000, rx_data0, tx_ready0}, 32'h0);
    rst = 1'b0;
    wait_cycles(2);
    cmd_log.delete(); rx_log.delete(); fe0 = fe_cnt;
    send(32'h12, 8, 4);
    send(32'h4444, 16, 4);
    check("armed_no_cmd", cmd_log.size(), 0);
    check("armed_no_rx", rx_log.size(), 0);
    end_frame();
    check("armed_no_frame_end", fe_cnt - fe0, 0);
    start_frame();
    send(32'h33, 8, 4);
    end_frame();
    check("rearm_cmd_count", cmd_log.size(), 1);
    check("rearm_cmd", cmd_log[0], 8'h33);

    // Single-lane, 8-bit words: cmd 0x21 then data 0x5A.
    sel = 1'b1;
    wait_cycles(2 * H);
    start_frame();
    send(32'h21 >> 1, 7, 1);
    check("l1_cmd_after7", cmd1_log.size(), 0);
    send(32'h1, 1, 1);
    check("l1_cmd_after8", cmd1_log.size(), 1);
    check("l1_cmd", cmd1_log[0], 8'h21);
    send(32'h5A >> 1, 7, 1);
    check("l1_rx_after15", rx1_log.size(), 0);
    send(32'h0, 1, 1);
    check("l1_rx_after16", rx1_log.size(), 1);
    check("l1_rx", rx1_log[0], 8'h5A);
    end_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_frame_link.md
# spi_frame_link

Parametrised serial target front-end for the chess engine's host link. It generalises the fixed quad-lane SPI pins (`sck`, `cs_n`, `sdi`, `sdo`) into a framed protocol engine with 1/2/4 selectable lanes and configurable word width. It has separate receive and transmit word interfaces, and a one-deep transmit prefetch buffer. It sits between the pad-level pins and the engine's command decoder, fully in the `clk` domain.

## Interface
- `LANES`, default 4: data lanes per SCK edge; legal values are 1, 2 and 4.
- `WORD_W`, default 16: payload word width; must be a multiple of 8.
- `SYNC_STAGES`, default 2: synchroniser depth on `sck`, `cs_n` and `sdi`; must be ≥ 2.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset; asynchronous, active-high.
- `sck` in 1: serial clock, CPOL=0/CPHA=0; asynchronous to `clk`.
- `cs_n` in 1: frame select, active-low; asynchronous.
- `sdi` in LANES: serial data in; lane LANES-1 carries the most significant bit.
- `sdo` out LANES: serial data out, same lane order as `sdi`.
- `sdo_oe` out 1: output enable for `sdo`.
- `cmd` out 8: received command byte.
- `cmd_valid` out 1: one-cycle strobe; `cmd` is valid.
- `rx_data` out WORD_W: received payload word.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` in WORD_W: word to transmit.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: a word is accepted when `tx_valid && tx_ready`.
- `frame_end` out 1: one-cycle strobe when `cs_n` deasserts.
- `underrun` out 1: one-cycle strobe when the shifter reloads with the hold buffer empty.

## Operation
- All outputs reset to 0. State resets to `ARMED`, and the hold buffer resets to empty.
- Each pin passes through `SYNC_STAGES` flops.
- A rising or falling SCK edge is detected from the last two synchronised samples.
- States and transitions:
  - `ARMED`: waits for synchronised `cs_n`=1, then goes to `IDLE`. This prevents joining a frame mid-stream after reset.
  - `IDLE`: on `cs_n` falling, goes to `CMD`.
  - `CMD`: on each rising edge, shifts LANES bits in, MSB first. After 8/LANES edges, `cmd` latches and `cmd_valid` pulses. If `cmd[7]`=1 the next state is `TX`, otherwise `RX`.
  - `RX`: shifts on rising edges. Every WORD_W/LANES edges, `rx_data` latches and `rx_valid` pulses. Words repeat until `cs_n` rises.
  - `TX`: `sdo_oe`=1. `sdo` updates on falling edges, MSB-first lane groups. At each word boundary (the first falling edge after `cmd`, then every WORD_W/LANES falling edges), the shifter loads from the hold buffer. If the buffer is empty, the shifter loads zeros and `underrun` pulses.
- Hold buffer: `tx_ready` = (state==`TX`) && hold empty. The buffer fills on handshake and empties on shifter load.
- `cs_n` rising in any state except `ARMED`: next state `IDLE`. `frame_end` pulses, a partial word is discarded with no `rx_valid`, the hold buffer is flushed, and `sdo_oe`/`sdo` go to 0.
- A simultaneous `cs_n` rising and SCK edge: `cs_n` wins, and the edge is ignored.
- A handshake in the same cycle as a shifter load takes the freed slot only if the buffer was empty before that load. There is never double occupancy.

## Timing
- Pin-to-decision latency is SYNC_STAGES+1 `clk` cycles.
- `cmd_valid` and `rx_valid` assert SYNC_STAGES+2 cycles after the final rising SCK edge of the field.
- `sdo` changes SYNC_STAGES+2 cycles after a falling SCK edge.
- SCK high and low phases must each be ≥ SYNC_STAGES+3 `clk` cycles; shorter phases are unsupported.
- `tx_ready` is registered. The first `tx_ready` asserts the cycle after `cmd_valid`.

## Structure
- `spi_link_pkg` holds:
  - the state enum (`ARMED`, `IDLE`, `CMD`, `RX`, `TX`);
  - `CMD_W`=8;
  - `CMD_READ_BIT`=7;
  - a function `beats(width, lanes)`.
- Sub-module `spi_pin_sync`: a parametrised-width synchroniser plus SCK rise/fall and `cs_n` rise/fall detection.

## Test plan
- Write frame, LANES=4, WORD_W=16: `cmd` 0x12, then 0xBEEF, 0x0001. Expect `cmd_valid` with 0x12, then `rx_valid` ×2 carrying 0xBEEF and 0x0001, then `frame_end`.
- Read frame: `cmd` 0x80; the bench offers 0xA5C3 and 0x1234 at `tx_ready`. Expect `sdo` nibbles A,5,C,3,1,2,3,4 with `sdo_oe`=1, and no `underrun`.
- Read underrun: `cmd` 0x81 with `tx_valid` held 0. Expect `sdo` 0x0000, an `underrun` pulse at the first word boundary, and `tx_ready` staying high.
- Abort: `cs_n` rises after 2 of 4 beats of an RX word. Expect no `rx_valid`, a `frame_end` pulse, and `IDLE`. The next frame decodes correctly.
- Reset mid-frame with `cs_n` held 0: all outputs 0, and nothing decodes until `cs_n` goes high then low. The next frame with `cmd` 0x33 gives `cmd_valid` 0x33.
- LANES=1, WORD_W=8: write 0x5A. Expect `cmd_valid` after 8 edges and `rx_data` 0x5A after 8 more edges.
